payoff_accumulator: RTL and testbench

PAYOFF_ACCUMULATOR -- requirements
Module: payoff_accumulator

---
 rtl/bs_pkg.sv | 23 ++
 rtl/payoff_lane.sv | 64 ++++++
 rtl/payoff_accumulator.sv | 185 ++++++++++++++++++
 tb/tb_payoff_accumulator.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared definitions for the payoff accumulator slice:
// command codes, state encodings and pipeline depth.
package bs_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RUNNING  = 4'd1,
    ST_COMPLETE = 4'd2,
    ST_DRAIN    = 4'd3
  } state_t;

  localparam logic [3:0] CMD_RUN   = 4'd1;
  localparam logic [3:0] CMD_ACK   = 4'd2;
  localparam logic [3:0] CMD_ABORT = 4'd3;

  // acceptance -> payoff reg -> square -> reduce -> accumulate
  localparam int PIPE_LAT = 4;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/payoff_lane.sv
// One sample lane: clamped call/put payoff, then truncated
// fixed-point square, each stage with its own valid.
module payoff_lane
  import bs_pkg::*;
#(
  parameter int  DIN_W  = 20,
  parameter int  FRAC_W = 12,
  localparam int SQ_W   = 2*DIN_W - FRAC_W
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic             i_mode,
  input  logic [DIN_W-1:0] i_k,
  input  logic [DIN_W-1:0] i_x,
  output logic             o_valid,
  output logic [DIN_W-1:0] o_p,
  output logic [SQ_W-1:0]  o_sq
);

  logic               r_v1;
  logic               r_v2;
  logic [DIN_W-1:0]   r_p1;
  logic [DIN_W-1:0]   r_p2;
  logic [SQ_W-1:0]    r_sq2;
  logic [DIN_W-1:0]   w_p;
  logic [2*DIN_W-1:0] w_prod;
  logic [SQ_W-1:0]    w_sq;

  always_comb begin
    w_p = '0;
    if (i_mode) begin
      if (i_k > i_x) w_p = i_k - i_x;
    end else begin
      if (i_x > i_k) w_p = i_x - i_k;
    end
  end

  assign w_prod = {{DIN_W{1'b0}}, r_p1}
                * {{DIN_W{1'b0}}, r_p1};
  assign w_sq   = SQ_W'(w_prod >> FRAC_W);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_p1  <= '0;
      r_p2  <= '0;
      r_sq2 <= '0;
    end else begin
      r_v1  <= i_valid & ~i_flush;
      r_v2  <= r_v1 & ~i_flush;
      r_p1  <= w_p;
      r_p2  <= r_p1;
      r_sq2 <= w_sq;
    end
  end

  assign o_valid = r_v2;
  assign o_p     = r_p2;
  assign o_sq    = r_sq2;

endmodule

// File: rtl/payoff_accumulator.sv
// Streams option payoffs and their squares into saturating
// accumulators under a RUN/ACK/ABORT command FSM.
module payoff_accumulator
  import bs_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DIN_W  = 20,
  parameter int FRAC_W = 12,
  parameter int ACC_W  = 64
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [3:0]             cmd,
  input  logic [31:0]            niter,
  input  logic [DIN_W-1:0]       constK,
  input  logic                   mode,
  input  logic                   din_valid,
  input  logic [LANES*DIN_W-1:0] din,
  output logic                   din_ready,
  output logic [3:0]             status,
  output logic [ACC_W-1:0]       sum_dout,
  output logic [ACC_W-1:0]       pow_sum_dout,
  output logic [31:0]            count_dout,
  output logic                   overflow
);

  localparam int SQ_W = 2*DIN_W - FRAC_W;
  localparam int CW   = $clog2(LANES + 1);
  localparam int PW   = DIN_W + CW;
  localparam int QW   = SQ_W + CW;
  localparam int TW   = imax(ACC_W, imax(PW, QW)) + 1;
  localparam int BV   = PIPE_LAT - 1;

  state_t           r_state;
  logic [31:0]      r_rem;
  logic [DIN_W-1:0] r_k;
  logic             r_mode;
  logic [BV-1:0]    r_bv;
  logic [PW-1:0]    r_red_p;
  logic [QW-1:0]    r_red_q;
  logic [CW-1:0]    r_red_n;
  logic [ACC_W-1:0] r_sum;
  logic [ACC_W-1:0] r_pow;
  logic [31:0]      r_cnt;
  logic             r_ovf;

  logic             w_ready;
  logic             w_abort;
  logic             w_acc;
  logic [31:0]      w_take;
  logic [LANES-1:0] w_lin;
  logic [LANES-1:0] w_lv;
  logic [DIN_W-1:0] w_lp [LANES];
  logic [SQ_W-1:0]  w_lq [LANES];
  logic [PW-1:0]    w_rp;
  logic [QW-1:0]    w_rq;
  logic [CW-1:0]    w_rn;
  logic [TW-1:0]    w_sum_ext;
  logic [TW-1:0]    w_pow_ext;
  logic             w_sum_sat;
  logic             w_pow_sat;

  assign w_ready = (r_state == ST_RUNNING) && (r_rem != '0);
  assign w_abort = (cmd == CMD_ABORT)
                && (r_state == ST_RUNNING || r_state == ST_DRAIN);
  assign w_acc   = din_valid && w_ready && !w_abort;
  assign w_take  = (r_rem < 32'(LANES)) ? r_rem : 32'(LANES);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    // lanes past the remaining count stay invalid
    assign w_lin[gi] = w_acc && (32'(gi) < r_rem);
    payoff_lane #(
      .DIN_W (DIN_W),
      .FRAC_W(FRAC_W)
    ) u_lane (
      .clk    (clk),
      .nreset (nreset),
      .i_flush(w_abort),
      .i_valid(w_lin[gi]),
      .i_mode (r_mode),
      .i_k    (r_k),
      .i_x    (din[gi*DIN_W +: DIN_W]),
      .o_valid(w_lv[gi]),
      .o_p    (w_lp[gi]),
      .o_sq   (w_lq[gi])
    );
  end

  always_comb begin
    w_rp = '0;
    w_rq = '0;
    w_rn = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_lv[i]) begin
        w_rp = w_rp + PW'(w_lp[i]);
        w_rq = w_rq + QW'(w_lq[i]);
        w_rn = w_rn + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_bv    <= '0;
      r_red_p <= '0;
      r_red_q <= '0;
      r_red_n <= '0;
    end else begin
      if (w_abort) r_bv <= '0;
      else         r_bv <= {r_bv[BV-2:0], w_acc};
      r_red_p <= w_rp;
      r_red_q <= w_rq;
      r_red_n <= w_rn;
    end
  end

  assign w_sum_ext = TW'(r_sum) + TW'(r_red_p);
  assign w_pow_ext = TW'(r_pow) + TW'(r_red_q);
  assign w_sum_sat = |w_sum_ext[TW-1:ACC_W];
  assign w_pow_sat = |w_pow_ext[TW-1:ACC_W];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_k     <= '0;
      r_mode  <= 1'b0;
      r_sum   <= '0;
      r_pow   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_bv[BV-1]) begin
        r_sum <= w_sum_sat ? '1 : w_sum_ext[ACC_W-1:0];
        r_pow <= w_pow_sat ? '1 : w_pow_ext[ACC_W-1:0];
        r_cnt <= r_cnt + 32'(r_red_n);
        if (w_sum_sat || w_pow_sat) r_ovf <= 1'b1;
      end
      if (w_abort) begin
        r_state <= ST_IDLE;
        r_rem   <= '0;
        r_sum   <= '0;
        r_pow   <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (cmd == CMD_RUN) begin
              r_rem   <= niter;
              r_k     <= constK;
              r_mode  <= mode;
              r_sum   <= '0;
              r_pow   <= '0;
              r_cnt   <= '0;
              r_ovf   <= 1'b0;
              r_state <= (niter == '0) ? ST_DRAIN : ST_RUNNING;
            end
          end
          ST_RUNNING: begin
            if (w_acc) begin
              r_rem <= r_rem - w_take;
              if (r_rem == w_take) r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (r_bv == '0) r_state <= ST_COMPLETE;
          end
          ST_COMPLETE: begin
            if (cmd == CMD_ACK) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign din_ready    = w_ready;
  assign status       = r_state;
  assign sum_dout     = r_sum;
  assign pow_sum_dout = r_pow;
  assign count_dout   = r_cnt;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_payoff_accumulator.sv
// Directed bench: a transaction-level model checks every cycle,
// a second instance with a narrow accumulator checks saturation.
module tb_payoff_accumulator;

  logic        clk = 1'b0;
  logic        nreset;
  logic [3:0]  cmd;
  logic [31:0] niter;
  logic [19:0] constK;
  logic [23:0] constK2;
  logic        mode;
  logic        din_valid;
  logic [39:0] din;
  logic [47:0] din2;

  logic        din_ready, overflow;
  logic [3:0]  status;
  logic [63:0] sum_dout, pow_sum_dout;
  logic [31:0] count_dout;

  logic        din_ready2, overflow2;
  logic [3:0]  status2;
  logic [23:0] sum2, pow2;
  logic [31:0] count2;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  payoff_accumulator #(
    .LANES(2), .DIN_W(20), .FRAC_W(12), .ACC_W(64)
  ) dut (
    .clk(clk), .nreset(nreset), .cmd(cmd), .niter(niter),
    .constK(constK), .mode(mode), .din_valid(din_valid),
    .din(din), .din_ready(din_ready), .status(status),
    .sum_dout(sum_dout), .pow_sum_dout(pow_sum_dout),
    .count_dout(count_dout), .overflow(overflow)
  );

  payoff_accumulator #(
    .LANES(2), .DIN_W(24), .FRAC_W(12), .ACC_W(24)
  ) dut_sat (
    .clk(clk), .nreset(nreset), .cmd(cmd), .niter(niter),
    .constK(constK2), .mode(mode), .din_valid(din_valid),
    .din(din2), .din_ready(din_ready2), .status(status2),
    .sum_dout(sum2), .pow_sum_dout(pow2),
    .count_dout(count2), .overflow(overflow2)
  );

  task automatic chk(string nm, longint unsigned act,
                     longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int              due;
    longint unsigned p;
    longint unsigned q;
    int              n;
  } upd_t;

  localparam longint unsigned MAXV = 64'hFFFF_FFFF_FFFF_FFFF;

  upd_t            mq[$];
  int              cyc   = 0;
  int              m_st  = 0;
  longint unsigned m_rem = 0;
  longint unsigned m_k   = 0;
  bit              m_put = 0;
  longint unsigned m_sum = 0;
  longint unsigned m_pow = 0;
  longint unsigned m_cnt = 0;
  bit              m_ovf = 0;

  function automatic longint unsigned pay(longint unsigned x,
    longint unsigned k, bit put);
    if (put) return (k > x) ? k - x : 0;
    return (x > k) ? x - k : 0;
  endfunction

  function automatic longint unsigned sadd(longint unsigned a,
    longint unsigned b, inout bit ovf);
    if (b > MAXV - a) begin
      ovf = 1;
      return MAXV;
    end
    return a + b;
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mq.delete();
      cyc = 0; m_st = 0; m_rem = 0; m_k = 0; m_put = 0;
      m_sum = 0; m_pow = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      bit   empty;
      upd_t u;
      cyc++;
      empty = (mq.size() == 0);
      if (!empty && mq[0].due == cyc) begin
        u = mq.pop_front();
        m_sum = sadd(m_sum, u.p, m_ovf);
        m_pow = sadd(m_pow, u.q, m_ovf);
        m_cnt += longint'(u.n);
      end
      if (cmd == 4'd3 && (m_st == 1 || m_st == 3)) begin
        mq.delete();
        m_st = 0; m_rem = 0;
        m_sum = 0; m_pow = 0; m_cnt = 0; m_ovf = 0;
      end else begin
        case (m_st)
          0: if (cmd == 4'd1) begin
               m_rem = niter; m_k = constK; m_put = mode;
               m_sum = 0; m_pow = 0; m_cnt = 0; m_ovf = 0;
               m_st = (niter == 0) ? 3 : 1;
             end
          1: if (din_valid) begin
               u.n = (m_rem < 2) ? int'(m_rem) : 2;
               u.p = 0; u.q = 0; u.due = cyc + 3;
               for (int i = 0; i < u.n; i++) begin
                 longint unsigned p;
                 p = pay(longint'(din[i*20 +: 20]), m_k, m_put);
                 u.p += p;
                 u.q += (p * p) >> 12;
               end
               mq.push_back(u);
               m_rem -= longint'(u.n);
               if (m_rem == 0) m_st = 3;
             end
          3: if (empty) m_st = 2;
          2: if (cmd == 4'd2) m_st = 0;
          default: m_st = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("status", status, longint'(m_st));
      chk("din_ready", din_ready, (m_st == 1 && m_rem > 0));
      chk("sum", sum_dout, m_sum);
      chk("pow_sum", pow_sum_dout, m_pow);
      chk("count", count_dout, m_cnt);
      chk("overflow", overflow, m_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(int n);
    repeat (n) sync();
  endtask

  task automatic do_cmd(logic [3:0] c);
    cmd = c;
    sync();
    cmd = 4'd0;
  endtask

  task automatic run(int n, logic [23:0] k, logic md);
    niter = n; constK = k[19:0]; constK2 = k; mode = md;
    do_cmd(4'd1);
  endtask

  task automatic beat(logic [23:0] a, logic [23:0] b);
    bit ok = 0;
    din = {b[19:0], a[19:0]};
    din2 = {b, a};
    din_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = din_ready;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL beat_timeout: got ready 0 expected 1");
    end
    sync();
    din_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 99;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (status == 4'd2) begin
        n = t;
        break;
      end
    end
    if (n == 99) begin
      n_vec++; n_err++;
      $display("FAIL complete_timeout: got status %0d expected 2",
               status);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    nreset = 0; cmd = 0; niter = 0; constK = 0; constK2 = 0;
    mode = 0; din_valid = 0; din = '0; din2 = '0;
    cmp_en = 1;
    @(negedge clk);
    chk("rst_status", status, 0);
    chk("rst_ready", din_ready, 0);
    chk("rst_sum", sum_dout, 0);
    sync();
    nreset = 1;
    tick(2);

    // put, K=10.0, two beats of (6.0, 6.0)
    run(4, 24'd40960, 1);
    beat(24'd24576, 24'd24576);
    beat(24'd24576, 24'd24576);
    wait_done(lat);
    chk("put_latency", lat, 5);
    chk("put_sum", sum_dout, 65536);
    chk("put_pow", pow_sum_dout, 262144);
    chk("put_cnt", count_dout, 4);
    sync();
    do_cmd(4'd1);
    do_cmd(4'd2);
    tick(2);
    chk("idle_hold_sum", sum_dout, 65536);

    // call with masked lane in last beat
    run(3, 24'd40960, 0);
    beat(24'd32768, 24'd49152);
    beat(24'd36864, 24'd81920);
    wait_done(lat);
    chk("call_sum", sum_dout, 8192);
    chk("call_pow", pow_sum_dout, 16384);
    chk("call_cnt", count_dout, 3);
    sync();
    do_cmd(4'd2);

    // niter = 0
    run(0, 24'd40960, 0);
    @(negedge clk);
    chk("zero_st_drain", status, 3);
    @(negedge clk);
    chk("zero_st_done", status, 2);
    chk("zero_sum", sum_dout, 0);
    chk("zero_cnt", count_dout, 0);
    sync();
    do_cmd(4'd2);

    // din_valid toggling, put K=1.0, samples 0.5
    run(6, 24'd4096, 1);
    for (int i = 0; i < 3; i++) begin
      beat(24'd2048, 24'd2048);
      tick(1);
    end
    wait_done(lat);
    chk("tog_sum", sum_dout, 12288);
    chk("tog_pow", pow_sum_dout, 6144);
    chk("tog_cnt", count_dout, 6);
    sync();
    do_cmd(4'd2);

    // saturation on the 24-bit instance: call, K=0, 2047.0
    run(8, 24'd0, 0);
    for (int i = 0; i < 4; i++) beat(24'd8384512, 24'd8384512);
    wait_done(lat);
    chk("sat_sum", sum2, 16777215);
    chk("sat_pow", pow2, 16777215);
    chk("sat_ovf", overflow2, 1);
    chk("sat_cnt", count2, 8);
    sync();
    do_cmd(4'd2);
    run(2, 24'd40960, 1);
    @(negedge clk);
    chk("sat_ovf_clear", overflow2, 0);
    sync();
    beat(24'd24576, 24'd24576);
    wait_done(lat);
    sync();
    do_cmd(4'd2);

    // ABORT with a beat in flight and din_valid held high
    run(4, 24'd40960, 1);
    beat(24'd24576, 24'd24576);
    din_valid = 1'b1;
    do_cmd(4'd3);
    din_valid = 1'b0;
    @(negedge clk);
    chk("abort_status", status, 0);
    chk("abort_sum", sum_dout, 0);
    tick(6);
    chk("abort_cnt", count_dout, 0);
    run(4, 24'd40960, 1);
    beat(24'd24576, 24'd24576);
    beat(24'd24576, 24'd24576);
    wait_done(lat);
    chk("abort_rerun_sum", sum_dout, 65536);
    sync();
    do_cmd(4'd2);

    // asynchronous reset pulse mid-run
    run(4, 24'd40960, 1);
    beat(24'd24576, 24'd24576);
    nreset = 0;
    @(negedge clk);
    chk("nrst_status", status, 0);
    chk("nrst_sum", sum_dout, 0);
    chk("nrst_ready", din_ready, 0);
    sync();
    nreset = 1;
    tick(4);
    chk("nrst_cnt", count_dout, 0);
    run(4, 24'd40960, 1);
    beat(24'd24576, 24'd24576);
    beat(24'd24576, 24'd24576);
    wait_done(lat);
    chk("nrst_rerun_sum", sum_dout, 65536);
    chk("nrst_rerun_pow", pow_sum_dout, 262144);
    sync();
    do_cmd(4'd2);
    tick(2);

    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
